// File: rtl/vertex_result_collector_pkg.sv
// Shared project package: vector width, node-id range and the collector FSM encoding.
package vertex_result_collector_pkg;

  // Partial-sum / result width used by the PEs and the collector.
  localparam int FV_size     = 16;
  // Largest node id in the graph; node ids are IDW bits wide.
  localparam int Max_Node_id = 100;
  localparam int IDW         = $clog2(Max_Node_id);

  // Collector state: IDLE holds nothing, ACCUM holds a partial sum in acc/acc_id.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } vrc_state_e;

endpackage

// File: rtl/vertex_result_collector_if.sv
// Bundle of the PE beat channel and the output-memory write channel.
// master drives beats and grants (PE / memory side), slave is the collector.
interface vertex_result_collector_if
  #(parameter int DW = vertex_result_collector_pkg::FV_size,
    parameter int AW = vertex_result_collector_pkg::IDW);

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [AW-1:0] in_node_id;
  logic          in_last;

  logic          wr_req;
  logic          wr_gnt;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  modport master (
    output in_valid, in_data, in_node_id, in_last, wr_gnt,
    input  in_ready, wr_req, wr_addr, wr_data
  );

  modport slave (
    input  in_valid, in_data, in_node_id, in_last, wr_gnt,
    output in_ready, wr_req, wr_addr, wr_data
  );

endinterface

// File: rtl/vertex_result_collector_result_fifo.sv
// Small register-based FIFO holding completed {node_id, result} entries.
// Head entry is presented combinationally from the storage registers.
module result_fifo #(
  parameter int WIDTH = 23,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head_data
);

  localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam logic [PTRW-1:0] LAST_PTR  = PTRW'(DEPTH - 1);
  localparam logic [CNTW-1:0] FULL_CNT  = CNTW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTRW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic             do_push_s;
  logic             do_pop_s;

  // Next-state for storage, pointers and occupancy; pointers wrap at DEPTH.
  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    do_push_s = push && (count_q != FULL_CNT);
    do_pop_s  = pop && (count_q != {CNTW{1'b0}});
    if (do_push_s) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? {PTRW{1'b0}} : wr_ptr_q + PTRW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? {PTRW{1'b0}} : rd_ptr_q + PTRW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers; reset clears storage so the head reads as zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_q <= {PTRW{1'b0}};
      rd_ptr_q <= {PTRW{1'b0}};
      count_q  <= {CNTW{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == {CNTW{1'b0}});
  assign head_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/vertex_result_collector.sv
// Vertex result collector: sums PE partial-sum beats per node and queues the
// finished node results for writing to output memory in completion order.
module vertex_result_collector #(
  parameter int FV_size     = vertex_result_collector_pkg::FV_size,
  parameter int Max_Node_id = vertex_result_collector_pkg::Max_Node_id,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  vertex_result_collector_if.slave         bus,
  output logic [15:0]                      node_cnt,
  output logic                             err_mismatch
);

  import vertex_result_collector_pkg::*;

  localparam int IDW = $clog2(Max_Node_id);
  localparam int EW  = IDW + FV_size;

  vrc_state_e         state_q, state_d;
  logic [FV_size-1:0] acc_q, acc_d;
  logic [IDW-1:0]     acc_id_q, acc_id_d;
  logic               err_q, err_d;
  logic [15:0]        cnt_q, cnt_d;

  logic               accept_s;
  logic               same_id_s;
  logic [FV_size-1:0] sum_s;
  logic               push_s;
  logic [EW-1:0]      push_data_s;
  logic               pop_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic [EW-1:0]      head_s;

  assign accept_s  = bus.in_valid && !fifo_full_s;
  assign same_id_s = (bus.in_node_id == acc_id_q);
  assign sum_s     = acc_q + bus.in_data;
  assign pop_s     = !fifo_empty_s && bus.wr_gnt;

  // FSM state register plus the datapath registers it controls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      acc_q    <= {FV_size{1'b0}};
      acc_id_q <= {IDW{1'b0}};
      err_q    <= 1'b0;
      cnt_q    <= 16'h0000;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      acc_id_q <= acc_id_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state: any accepted last beat ends in IDLE, a non-last beat ends in ACCUM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s && !bus.in_last) begin
          state_d = ST_ACCUM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (accept_s && bus.in_last) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ACCUM;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath/outputs: accumulate, push finished nodes, flag id changes mid-node.
  always_comb begin
    acc_d       = acc_q;
    acc_id_d    = acc_id_q;
    err_d       = err_q;
    push_s      = 1'b0;
    push_data_s = {EW{1'b0}};
    if (accept_s) begin
      if ((state_q == ST_ACCUM) && same_id_s) begin
        if (bus.in_last) begin
          push_s      = 1'b1;
          push_data_s = {acc_id_q, sum_s};
        end else begin
          acc_d = sum_s;
        end
      end else begin
        // A different id while accumulating drops the old partial sum.
        if (state_q == ST_ACCUM) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
        if (bus.in_last) begin
          push_s      = 1'b1;
          push_data_s = {bus.in_node_id, bus.in_data};
        end else begin
          acc_d    = bus.in_data;
          acc_id_d = bus.in_node_id;
        end
      end
    end else begin
      push_s = 1'b0;
    end
    if (pop_s && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  result_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_result_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .head_data (head_s)
  );

  assign bus.in_ready = !fifo_full_s;
  assign bus.wr_req   = !fifo_empty_s;
  assign bus.wr_addr  = head_s[FV_size +: IDW];
  assign bus.wr_data  = head_s[FV_size-1:0];
  assign node_cnt     = cnt_q;
  assign err_mismatch = err_q;

endmodule

// File: tb/tb_vertex_result_collector.sv
// Directed bench for vertex_result_collector: a beat table plus hand-written
// sequences for backpressure, write stall and reset in mid-operation.
module tb_vertex_result_collector;
  import vertex_result_collector_pkg::*;

  logic        clk;
  logic        reset;
  logic [15:0] node_cnt;
  logic        err_mismatch;
  int          checks;
  int          failures;

  vertex_result_collector_if #(.DW(FV_size), .AW(IDW)) bus ();

  vertex_result_collector dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .node_cnt     (node_cnt),
    .err_mismatch (err_mismatch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [IDW-1:0]     id;
    logic [FV_size-1:0] data;
    logic               last;
    logic               exp_wr;
    logic [IDW-1:0]     exp_addr;
    logic [FV_size-1:0] exp_data;
    logic               exp_err;
    logic [15:0]        exp_cnt;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One accepted beat: drive at negedge, accept on posedge, back at negedge.
  task automatic send(input logic [IDW-1:0] id, input logic [FV_size-1:0] d, input logic last);
    bus.in_node_id = id;
    bus.in_data    = d;
    bus.in_last    = last;
    bus.in_valid   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid   = 1'b0;
  endtask

  logic [IDW-1:0]     hold_addr;
  logic [FV_size-1:0] hold_data;
  logic               acc_now;
  int                 nwr;

  initial begin
    checks = 0;
    failures = 0;
    bus.in_valid = 1'b0; bus.in_data = 16'h0000; bus.in_node_id = 7'd0;
    bus.in_last = 1'b0; bus.wr_gnt = 1'b0;
    reset = 1'b0;
    //        id     data      last  wr    addr   data      err   cnt
    vecs[0]  = '{7'd5,  16'd3,    1'b0, 1'b0, 7'd0,  16'd0,    1'b0, 16'd0};
    vecs[1]  = '{7'd5,  16'd4,    1'b0, 1'b0, 7'd0,  16'd0,    1'b0, 16'd0};
    vecs[2]  = '{7'd5,  16'd10,   1'b1, 1'b1, 7'd5,  16'd17,   1'b0, 16'd1};
    vecs[3]  = '{7'd2,  16'hFFFF, 1'b0, 1'b0, 7'd0,  16'd0,    1'b0, 16'd1};
    vecs[4]  = '{7'd2,  16'h0002, 1'b1, 1'b1, 7'd2,  16'h0001, 1'b0, 16'd2};
    vecs[5]  = '{7'd3,  16'd7,    1'b0, 1'b0, 7'd0,  16'd0,    1'b0, 16'd2};
    vecs[6]  = '{7'd4,  16'd9,    1'b1, 1'b1, 7'd4,  16'd9,    1'b1, 16'd3};
    vecs[7]  = '{7'd99, 16'h8000, 1'b1, 1'b1, 7'd99, 16'h8000, 1'b1, 16'd4};
    vecs[8]  = '{7'd0,  16'd1,    1'b0, 1'b0, 7'd0,  16'd0,    1'b1, 16'd4};
    vecs[9]  = '{7'd0,  16'hFFFF, 1'b0, 1'b0, 7'd0,  16'd0,    1'b1, 16'd4};
    vecs[10] = '{7'd0,  16'd5,    1'b1, 1'b1, 7'd0,  16'd5,    1'b1, 16'd5};

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_wr_req", 32'(bus.wr_req), 32'd0);
    chk("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
    chk("rst_wr_data", 32'(bus.wr_data), 32'd0);
    chk("rst_node_cnt", 32'(node_cnt), 32'd0);
    chk("rst_err", 32'(err_mismatch), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    reset = 1'b1;
    @(negedge clk);

    // Table: one beat per vector, then drain any completed node with a 1-cycle grant.
    for (int i = 0; i < 11; i++) begin
      chk($sformatf("v%0d_in_ready", i), 32'(bus.in_ready), 32'd1);
      send(vecs[i].id, vecs[i].data, vecs[i].last);
      chk($sformatf("v%0d_wr_req", i), 32'(bus.wr_req), 32'(vecs[i].exp_wr));
      chk($sformatf("v%0d_err", i), 32'(err_mismatch), 32'(vecs[i].exp_err));
      if (vecs[i].exp_wr) begin
        chk($sformatf("v%0d_wr_addr", i), 32'(bus.wr_addr), 32'(vecs[i].exp_addr));
        chk($sformatf("v%0d_wr_data", i), 32'(bus.wr_data), 32'(vecs[i].exp_data));
        bus.wr_gnt = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.wr_gnt = 1'b0;
        chk($sformatf("v%0d_drained", i), 32'(bus.wr_req), 32'd0);
      end
      chk($sformatf("v%0d_node_cnt", i), 32'(node_cnt), 32'(vecs[i].exp_cnt));
    end

    // Backpressure: four results fill the FIFO, the fifth beat is held.
    for (int i = 1; i <= 4; i++) begin
      send(7'(i), 16'(i * 10), 1'b1);
      chk($sformatf("bp_in_ready_%0d", i), 32'(bus.in_ready), (i == 4) ? 32'd0 : 32'd1);
    end
    bus.in_node_id = 7'd5; bus.in_data = 16'd50; bus.in_last = 1'b1; bus.in_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("bp_held_ready", 32'(bus.in_ready), 32'd0);
    chk("bp_head_addr", 32'(bus.wr_addr), 32'd1);
    chk("bp_cnt_hold", 32'(node_cnt), 32'd5);
    bus.wr_gnt = 1'b1;
    nwr = 0;
    for (int c = 0; c < 30 && nwr < 5; c++) begin
      if (bus.wr_req) begin
        chk($sformatf("bp_wr%0d_addr", nwr), 32'(bus.wr_addr), 32'(nwr + 1));
        chk($sformatf("bp_wr%0d_data", nwr), 32'(bus.wr_data), 32'((nwr + 1) * 10));
        nwr++;
      end
      acc_now = bus.in_valid && bus.in_ready;
      @(posedge clk);
      @(negedge clk);
      if (acc_now) bus.in_valid = 1'b0;
    end
    bus.wr_gnt = 1'b0;
    bus.in_valid = 1'b0;
    chk("bp_write_count", 32'(nwr), 32'd5);
    chk("bp_empty", 32'(bus.wr_req), 32'd0);
    chk("bp_node_cnt", 32'(node_cnt), 32'd10);

    // Grant stalled three cycles: head stays stable, one pop on the grant.
    send(7'd9, 16'h1234, 1'b1);
    chk("stall_wr_req", 32'(bus.wr_req), 32'd1);
    hold_addr = bus.wr_addr;
    hold_data = bus.wr_data;
    chk("stall_addr0", 32'(hold_addr), 32'd9);
    chk("stall_data0", 32'(hold_data), 32'h1234);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("stall_addr_c%0d", c), 32'(bus.wr_addr), 32'(hold_addr));
      chk($sformatf("stall_data_c%0d", c), 32'(bus.wr_data), 32'(hold_data));
      chk($sformatf("stall_req_c%0d", c), 32'(bus.wr_req), 32'd1);
    end
    bus.wr_gnt = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.wr_gnt = 1'b0;
    chk("stall_popped", 32'(bus.wr_req), 32'd0);
    chk("stall_node_cnt", 32'(node_cnt), 32'd11);

    // Reset with two queued results and a partial sum in progress.
    send(7'd20, 16'd1, 1'b1);
    send(7'd21, 16'd2, 1'b1);
    send(7'd22, 16'd3, 1'b0);
    chk("mid_wr_req", 32'(bus.wr_req), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("async_wr_req", 32'(bus.wr_req), 32'd0);
    chk("async_node_cnt", 32'(node_cnt), 32'd0);
    chk("async_err", 32'(err_mismatch), 32'd0);
    chk("async_wr_addr", 32'(bus.wr_addr), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    bus.wr_gnt = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("post_rst_no_wr_c%0d", c), 32'(bus.wr_req), 32'd0);
    end
    chk("post_rst_cnt", 32'(node_cnt), 32'd0);
    bus.wr_gnt = 1'b0;
    send(7'd22, 16'd4, 1'b1);
    chk("post_rst_fresh_addr", 32'(bus.wr_addr), 32'd22);
    chk("post_rst_fresh_data", 32'(bus.wr_data), 32'd4);
    chk("post_rst_fresh_err", 32'(err_mismatch), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
